// File: rtl/icb_rr_arbiter.sv
// icb_rr_arbiter: round-robin N-master ICB arbiter onto one slave, in-order response routing via grant-ID FIFO; optional ICB_ARB_GNT_CNT_EN adds per-master grant counters
module icb_rr_arbiter #(
  parameter int N_MST = 2,
  parameter int AW    = 32,
  parameter int OUTS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MST-1:0]    m_cmd_valid,
  output logic [N_MST-1:0]    m_cmd_ready,
  input  logic [N_MST*AW-1:0] m_cmd_addr,
  input  logic [N_MST-1:0]    m_cmd_read,
  input  logic [N_MST*32-1:0] m_cmd_wdata,
  input  logic [N_MST*4-1:0]  m_cmd_wmask,
  output logic [N_MST-1:0]    m_rsp_valid,
  input  logic [N_MST-1:0]    m_rsp_ready,
  output logic [N_MST-1:0]    m_rsp_err,
  output logic [N_MST*32-1:0] m_rsp_rdata,
  output logic                s_cmd_valid,
  input  logic                s_cmd_ready,
  output logic [AW-1:0]       s_cmd_addr,
  output logic                s_cmd_read,
  output logic [31:0]         s_cmd_wdata,
  output logic [3:0]          s_cmd_wmask,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic                s_rsp_err,
  input  logic [31:0]         s_rsp_rdata,
`ifdef ICB_ARB_GNT_CNT_EN
  output logic                orphan_rsp,
  output logic [N_MST*16-1:0] gnt_cnt
`else
  output logic                orphan_rsp
`endif
);
  localparam int IW = N_MST > 1 ? $clog2(N_MST) : 1;
  localparam int PW = OUTS > 1 ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS) + 1;

  logic [IW-1:0] r_rr_ptr, r_lidx, w_gidx, w_idx, w_head;
  logic          r_lock, r_orphan;
  logic [IW-1:0] r_fifo [OUTS];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_full, w_empty, w_push, w_pop;

  assign w_full     = r_cnt == CW'(OUTS);
  assign w_empty    = r_cnt == '0;
  assign w_head     = r_fifo[r_rd];
  assign w_push     = s_cmd_valid & s_cmd_ready;
  assign w_pop      = ~w_empty & s_rsp_valid & s_rsp_ready;
  assign orphan_rsp = r_orphan;

  // pick first requester at or after rr_ptr; a stalled grant stays locked
  always_comb begin
    w_gidx = r_rr_ptr;
    w_idx  = '0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % N_MST);
      if (m_cmd_valid[w_idx]) w_gidx = w_idx;
    end
    if (r_lock) w_gidx = r_lidx;
  end

  // command mux from the granted master; ready only to the winner
  always_comb begin
    s_cmd_valid = m_cmd_valid[w_gidx] & ~w_full;
    s_cmd_addr  = '0;
    s_cmd_read  = 1'b0;
    s_cmd_wdata = '0;
    s_cmd_wmask = '0;
    m_cmd_ready = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (w_gidx == IW'(i)) begin
        s_cmd_addr     = m_cmd_addr[i*AW +: AW];
        s_cmd_read     = m_cmd_read[i];
        s_cmd_wdata    = m_cmd_wdata[i*32 +: 32];
        s_cmd_wmask    = m_cmd_wmask[i*4 +: 4];
        m_cmd_ready[i] = s_cmd_ready & ~w_full;
      end
    end
  end

  // route the slave response to the master at the FIFO head; drain when empty
  always_comb begin
    m_rsp_valid = '0;
    m_rsp_err   = '0;
    m_rsp_rdata = {N_MST{s_rsp_rdata}};
    s_rsp_ready = w_empty | m_rsp_ready[w_head];
    for (int i = 0; i < N_MST; i++) begin
      m_rsp_valid[i] = ~w_empty & (w_head == IW'(i)) & s_rsp_valid;
      m_rsp_err[i]   = ~w_empty & (w_head == IW'(i)) & s_rsp_err;
    end
  end

  // round-robin pointer, grant lock and orphan flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_lock   <= 1'b0;
      r_lidx   <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= (w_gidx == IW'(N_MST - 1)) ? '0 : w_gidx + 1'b1;
        r_lock   <= 1'b0;
      end else if (s_cmd_valid) begin
        r_lock <= 1'b1;
        r_lidx <= w_gidx;
      end
      if (w_empty & s_rsp_valid) r_orphan <= 1'b1;
    end
  end

  // grant-ID FIFO tracking which master owns each outstanding command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= w_gidx;
        r_wr         <= (r_wr == PW'(OUTS - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == PW'(OUTS - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= (w_push & ~w_pop) ? r_cnt + 1'b1 : (w_pop & ~w_push) ? r_cnt - 1'b1 : r_cnt;
    end
  end

`ifdef ICB_ARB_GNT_CNT_EN
  // saturating per-master grant counters
  always_ff @(posedge clk) begin
    if (rst) gnt_cnt <= '0;
    else
      for (int i = 0; i < N_MST; i++)
        if (w_push && w_gidx == IW'(i) && gnt_cnt[i*16 +: 16] != 16'hFFFF)
          gnt_cnt[i*16 +: 16] <= gnt_cnt[i*16 +: 16] + 16'd1;
  end
`else
`endif
endmodule

// File: tb/tb_icb_rr_arbiter.sv
// tb_icb_rr_arbiter: directed scoreboard bench for icb_rr_arbiter (N_MST=2, OUTS=4)
module tb_icb_rr_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  m_cmd_valid = '0, m_cmd_ready, m_cmd_read = '0;
  logic [63:0] m_cmd_addr = '0, m_cmd_wdata = '0, m_rsp_rdata;
  logic [7:0]  m_cmd_wmask = '0;
  logic [1:0]  m_rsp_valid, m_rsp_ready = '0, m_rsp_err;
  logic        s_cmd_valid, s_cmd_ready = 1'b0, s_cmd_read;
  logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata = '0;
  logic [3:0]  s_cmd_wmask;
  logic        s_rsp_valid = 1'b0, s_rsp_ready, s_rsp_err = 1'b0, orphan_rsp;
`ifdef ICB_ARB_GNT_CNT_EN
  logic [31:0] gnt_cnt;
`endif

  icb_rr_arbiter #(.N_MST(2), .AW(32), .OUTS(4)) dut (
    .clk(clk), .rst(rst),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
    .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_err(m_rsp_err),
    .m_rsp_rdata(m_rsp_rdata),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
    .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_err(s_rsp_err),
    .s_rsp_rdata(s_rsp_rdata),
`ifdef ICB_ARB_GNT_CNT_EN
    .orphan_rsp(orphan_rsp), .gnt_cnt(gnt_cnt)
`else
    .orphan_rsp(orphan_rsp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int m; logic [31:0] d;} exp_t;
  exp_t        exp_q [$];
  logic [31:0] slv_q [$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          n_cmp = 0, n_err = 0;
  bit          rsp_en = 1'b0, orphan_force = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_m(input int i, input bit v, input bit rd, input logic [31:0] a, input logic [31:0] d);
    m_cmd_valid[i]           = v;
    m_cmd_read[i]            = rd;
    m_cmd_addr[i*32 +: 32]   = a;
    m_cmd_wdata[i*32 +: 32]  = d;
    m_cmd_wmask[i*4 +: 4]    = 4'hF;
  endtask

  task automatic drive_rsp();
    s_rsp_valid = orphan_force | (rsp_en && slv_q.size() != 0);
    s_rsp_rdata = (rsp_en && slv_q.size() != 0) ? slv_q[0] : 32'h0;
  endtask

  task automatic step();
    logic [31:0] a;
    exp_t e;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_cmd_valid[i] && m_cmd_ready[i]) begin
        a = m_cmd_addr[i*32 +: 32];
        e.m = i;
        e.d = m_cmd_read[i] ? (ref_mem.exists(a) ? ref_mem[a] : 32'h0) : 32'h0;
        exp_q.push_back(e);
        if (!m_cmd_read[i]) ref_mem[a] = m_cmd_wdata[i*32 +: 32];
      end
    end
    if (s_cmd_valid && s_cmd_ready) begin
      slv_q.push_back(s_cmd_read ? (mem.exists(s_cmd_addr) ? mem[s_cmd_addr] : 32'h0) : 32'h0);
      if (!s_cmd_read) mem[s_cmd_addr] = s_cmd_wdata;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_rsp_valid[i] && m_rsp_ready[i]) begin
        chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_master", 64'(i), 64'(e.m));
          chk("rsp_rdata", 64'(m_rsp_rdata[i*32 +: 32]), 64'(e.d));
        end
      end
    end
    if (s_rsp_valid && s_rsp_ready && slv_q.size() != 0 && rsp_en) void'(slv_q.pop_front());
    @(posedge clk);
    #1;
    drive_rsp();
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 30) begin
      step();
      b++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("idle_m_cmd_ready", 64'(m_cmd_ready), 64'd0);
    chk("idle_m_rsp_valid", 64'(m_rsp_valid), 64'd0);
    chk("idle_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
    chk("idle_s_rsp_ready", 64'(s_rsp_ready), 64'd1);
    chk("idle_orphan", 64'(orphan_rsp), 64'd0);
    step();
    s_cmd_ready = 1'b1;
    m_rsp_ready = 2'b11;
    rsp_en      = 1'b1;
    set_m(0, 1, 0, 32'h10, 32'hA5A5A5A5);
    set_m(1, 1, 1, 32'h10, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", 64'(m_cmd_ready), (k % 2) ? 64'd2 : 64'd1);
      if (k == 2) begin
        chk("rd_rsp_to_m1", 64'(m_rsp_valid), 64'd2);
        chk("rd_rsp_data", 64'(m_rsp_rdata[63:32]), 64'hA5A5A5A5);
      end
      step();
    end
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    drain();
    s_cmd_ready = 1'b0;
    set_m(0, 1, 0, 32'h100, 32'hDEADBEEF);
    #1;
    chk("lock_s_cmd_valid", 64'(s_cmd_valid), 64'd1);
    chk("lock_addr0", 64'(s_cmd_addr), 64'h100);
    step();
    set_m(1, 1, 1, 32'h200, 32'h0);
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("lock_addr_held", 64'(s_cmd_addr), 64'h100);
      chk("lock_no_ready", 64'(m_cmd_ready), 64'd0);
      step();
    end
    s_cmd_ready = 1'b1;
    #1;
    chk("lock_release_m0", 64'(m_cmd_ready), 64'd1);
    step();
    #1;
    chk("after_lock_m1", 64'(m_cmd_ready), 64'd2);
    chk("after_lock_addr", 64'(s_cmd_addr), 64'h200);
    step();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    drain();
    rsp_en = 1'b0;
    drive_rsp();
    set_m(0, 1, 1, 32'h100, 32'h0);
    set_m(1, 1, 1, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_grant", 64'(m_cmd_ready), (k % 2) ? 64'd2 : 64'd1);
      step();
    end
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("full_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
      chk("full_m_cmd_ready", 64'(m_cmd_ready), 64'd0);
      step();
    end
    rsp_en = 1'b1;
    drive_rsp();
    #1;
    chk("full_pop_no_push", 64'(s_cmd_valid), 64'd0);
    chk("full_head_m0", 64'(m_rsp_valid), 64'd1);
    step();
    #1;
    chk("fifth_issued", 64'(m_cmd_ready), 64'd1);
    step();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    drain();
    rsp_en = 1'b0;
    drive_rsp();
    set_m(1, 1, 1, 32'h10, 32'h0);
    #1;
    chk("bp_grant_m1", 64'(m_cmd_ready), 64'd2);
    step();
    set_m(1, 0, 0, 0, 0);
    m_rsp_ready = 2'b01;
    rsp_en      = 1'b1;
    drive_rsp();
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("bp_rsp_valid", 64'(m_rsp_valid), 64'd2);
      chk("bp_s_rsp_ready", 64'(s_rsp_ready), 64'd0);
      chk("bp_rdata", 64'(m_rsp_rdata[63:32]), 64'hA5A5A5A5);
      step();
    end
    m_rsp_ready = 2'b11;
    drain();
    orphan_force = 1'b1;
    drive_rsp();
    #1;
    chk("orphan_drain_ready", 64'(s_rsp_ready), 64'd1);
    chk("orphan_no_route", 64'(m_rsp_valid), 64'd0);
    chk("orphan_before", 64'(orphan_rsp), 64'd0);
    step();
    orphan_force = 1'b0;
    drive_rsp();
    #1;
    chk("orphan_set", 64'(orphan_rsp), 64'd1);
    step();
    step();
    step();
    chk("orphan_sticky", 64'(orphan_rsp), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("orphan_cleared", 64'(orphan_rsp), 64'd0);
    chk("rst_s_rsp_ready", 64'(s_rsp_ready), 64'd1);
`ifdef ICB_ARB_GNT_CNT_EN
    set_m(1, 1, 1, 32'h10, 32'h0);
    for (int k = 0; k < 3; k++) step();
    set_m(1, 0, 0, 0, 0);
    drain();
    chk("gnt_cnt_m1", 64'(gnt_cnt[31:16]), 64'd3);
    chk("gnt_cnt_m0", 64'(gnt_cnt[15:0]), 64'd0);
`endif
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
